uart_tx_scheduler: RTL and testbench

- Sequences the UART transmitter and shares it between two requesters in the system clock domain.
- Requester 1 is the ALU result channel: 16-bit, sent low byte then high byte. Requester 2 is the register-file read channel: 8-bit, one byte.
- Latches each request, arbitrates round-robin, drives one byte at a time into the UART TX, and tracks the transmitter's busy flag to know when each frame is finished.

---
 rtl/uart_pkg.sv | 16 +
 rtl/tx_rr_arbiter.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM states, grant codes, default byte width.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3
  } state_e;

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_RD  = 1'b1;

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-way round-robin arbiter; req[0] is the ALU channel, req[1] the read channel.
module tx_rr_arbiter
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_c
);

  logic last_grant_q;
  logic last_grant_d;

  // History only moves on a genuine tie, so a lone requester never steals the next turn.
  always_comb begin
    gnt_c        = GNT_ALU;
    last_grant_d = last_grant_q;
    if (&req) begin
      gnt_c = ~last_grant_q;
    end else if (req[1]) begin
      gnt_c = GNT_RD;
    end
    if (advance && (&req)) begin
      last_grant_d = gnt_c;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_grant_q <= GNT_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between the 16-bit ALU result channel and the 8-bit register read
// channel: latches requests, arbitrates round-robin and paces bytes on the transmitter busy flag.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VLD,
  input  logic [DATA_WIDTH-1:0]   RD_DATA,
  input  logic                    RD_VLD,
  input  logic                    TX_BUSY,
  input  logic                    CLR_ERR,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    SCHED_BUSY,
  output logic                    OVERFLOW,
  output logic                    ACK_ERR
);

  localparam int unsigned AW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e                state_q,      state_d;
  logic [AW-1:0]         alu_hold_q,   alu_hold_d;
  logic [DATA_WIDTH-1:0] rd_hold_q,    rd_hold_d;
  logic [1:0]            pend_q,       pend_d;
  logic                  gnt_q,        gnt_d;
  logic                  byte_idx_q,   byte_idx_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q,  tx_p_data_d;
  logic                  tx_d_vld_q,   tx_d_vld_d;
  logic                  sched_busy_q, sched_busy_d;
  logic                  overflow_q,   overflow_d;
  logic                  ack_err_q,    ack_err_d;

  logic       arb_gnt_c;
  logic       advance_c;
  logic [1:0] clr_c;
  logic       ovf_set_c;
  logic       ack_set_c;

  tx_rr_arbiter u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (pend_q),
    .advance (advance_c),
    .gnt_c   (arb_gnt_c)
  );

  always_comb begin
    state_d     = state_q;
    alu_hold_d  = alu_hold_q;
    rd_hold_d   = rd_hold_q;
    pend_d      = pend_q;
    gnt_d       = gnt_q;
    byte_idx_d  = byte_idx_q;
    cnt_d       = cnt_q;
    tx_p_data_d = tx_p_data_q;
    tx_d_vld_d  = 1'b0;
    overflow_d  = overflow_q;
    ack_err_d   = ack_err_q;
    advance_c   = 1'b0;
    clr_c       = 2'b00;
    ovf_set_c   = 1'b0;
    ack_set_c   = 1'b0;

    // Strobe and byte are registered on entry to ISSUE so they are visible during ISSUE itself.
    unique case (state_q)
      IDLE: begin
        if ((|pend_q) && !TX_BUSY) begin
          advance_c   = 1'b1;
          gnt_d       = arb_gnt_c;
          byte_idx_d  = 1'b0;
          tx_p_data_d = (arb_gnt_c == GNT_RD) ? rd_hold_q : alu_hold_q[DATA_WIDTH-1:0];
          tx_d_vld_d  = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (TX_BUSY) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
            ack_set_c = 1'b1;
            clr_c     = (gnt_q == GNT_RD) ? 2'b10 : 2'b01;
            state_d   = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if ((gnt_q == GNT_ALU) && !byte_idx_q) begin
            byte_idx_d  = 1'b1;
            tx_p_data_d = alu_hold_q[AW-1:DATA_WIDTH];
            tx_d_vld_d  = 1'b1;
            state_d     = ISSUE;
          end else begin
            clr_c   = (gnt_q == GNT_RD) ? 2'b10 : 2'b01;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new pulse beats a same-cycle clear and only counts as overflow if the old request survives.
    if (ALU_VLD) begin
      alu_hold_d = ALU_OUT;
      pend_d[0]  = 1'b1;
      ovf_set_c  = pend_q[0] && !clr_c[0];
    end else if (clr_c[0]) begin
      pend_d[0] = 1'b0;
    end
    if (RD_VLD) begin
      rd_hold_d = RD_DATA;
      pend_d[1] = 1'b1;
      ovf_set_c = ovf_set_c || (pend_q[1] && !clr_c[1]);
    end else if (clr_c[1]) begin
      pend_d[1] = 1'b0;
    end

    if (ovf_set_c) begin
      overflow_d = 1'b1;
    end else if (CLR_ERR) begin
      overflow_d = 1'b0;
    end
    if (ack_set_c) begin
      ack_err_d = 1'b1;
    end else if (CLR_ERR) begin
      ack_err_d = 1'b0;
    end

    sched_busy_d = (state_d != IDLE) || (|pend_d);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      alu_hold_q   <= '0;
      rd_hold_q    <= '0;
      pend_q       <= 2'b00;
      gnt_q        <= GNT_ALU;
      byte_idx_q   <= 1'b0;
      cnt_q        <= '0;
      tx_p_data_q  <= '0;
      tx_d_vld_q   <= 1'b0;
      sched_busy_q <= 1'b0;
      overflow_q   <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_hold_q   <= alu_hold_d;
      rd_hold_q    <= rd_hold_d;
      pend_q       <= pend_d;
      gnt_q        <= gnt_d;
      byte_idx_q   <= byte_idx_d;
      cnt_q        <= cnt_d;
      tx_p_data_q  <= tx_p_data_d;
      tx_d_vld_q   <= tx_d_vld_d;
      sched_busy_q <= sched_busy_d;
      overflow_q   <= overflow_d;
      ack_err_q    <= ack_err_d;
    end
  end

  assign TX_P_DATA  = tx_p_data_q;
  assign TX_D_VLD   = tx_d_vld_q;
  assign SCHED_BUSY = sched_busy_q;
  assign OVERFLOW   = overflow_q;
  assign ACK_ERR    = ack_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART TX busy model and a strobe log.
module tb_uart_tx_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        ALU_VLD;
  logic [7:0]  RD_DATA;
  logic        RD_VLD;
  logic        TX_BUSY;
  logic        CLR_ERR;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        SCHED_BUSY;
  logic        OVERFLOW;
  logic        ACK_ERR;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   tph    = 0;
  logic model_en   = 1'b1;
  logic force_busy = 1'b0;

  logic [7:0] log_q[$];
  int         log_cyc[$];

  uart_tx_scheduler #(.DATA_WIDTH(8), .ACK_TIMEOUT(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ALU_OUT    (ALU_OUT),
    .ALU_VLD    (ALU_VLD),
    .RD_DATA    (RD_DATA),
    .RD_VLD     (RD_VLD),
    .TX_BUSY    (TX_BUSY),
    .CLR_ERR    (CLR_ERR),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .SCHED_BUSY (SCHED_BUSY),
    .OVERFLOW   (OVERFLOW),
    .ACK_ERR    (ACK_ERR)
  );

  always #5 CLK = ~CLK;

  // UART TX model: busy rises two cycles after the strobe and stays high for an 11-cycle frame.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (TX_D_VLD)       tph <= 1;
    else if (tph == 13) tph <= 0;
    else if (tph != 0)  tph <= tph + 1;
  end
  assign TX_BUSY = force_busy | (model_en & (tph >= 2) & (tph <= 12));

  always @(negedge CLK) begin
    if (TX_D_VLD) begin
      log_q.push_back(TX_P_DATA);
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lg(input int i);
    lg = (log_q.size() > i) ? log_q[i] : 8'hxx;
  endfunction

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic pulse_alu(input logic [15:0] v);
    ALU_OUT = v; ALU_VLD = 1'b1;
    @(negedge CLK);
    ALU_VLD = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] v);
    RD_DATA = v; RD_VLD = 1'b1;
    @(negedge CLK);
    RD_VLD = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (SCHED_BUSY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_idle"}, 32'(SCHED_BUSY), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!TX_D_VLD && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_strobe"}, 32'(TX_D_VLD), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data"},  32'(TX_P_DATA),  32'd0);
    check({tag, "_vld"},   32'(TX_D_VLD),   32'd0);
    check({tag, "_busy"},  32'(SCHED_BUSY), 32'd0);
    check({tag, "_ovf"},   32'(OVERFLOW),   32'd0);
    check({tag, "_ackerr"},32'(ACK_ERR),    32'd0);
  endtask

  initial begin
    RST = 1'b0; ALU_OUT = '0; ALU_VLD = 1'b0; RD_DATA = '0; RD_VLD = 1'b0; CLR_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    check_quiet("rst");
    RST = 1'b1;
    @(negedge CLK);

    // Single read byte, two-cycle latency, one-cycle strobe.
    clear_log();
    pulse_rd(8'hA5);
    check("t1_vld_c1", 32'(TX_D_VLD), 32'd0);
    check("t1_busy_c1", 32'(SCHED_BUSY), 32'd1);
    @(negedge CLK);
    check("t1_vld_c2", 32'(TX_D_VLD), 32'd1);
    check("t1_data", 32'(TX_P_DATA), 32'hA5);
    @(negedge CLK);
    check("t1_vld_c3", 32'(TX_D_VLD), 32'd0);
    wait_idle("t1");
    check("t1_count", 32'(log_q.size()), 32'd1);
    check("t1_byte", 32'(lg(0)), 32'hA5);
    check("t1_hold", 32'(TX_P_DATA), 32'hA5);

    // ALU word: low then high byte, second strobe only once the frame ends.
    clear_log();
    pulse_alu(16'h1234);
    wait_idle("t2");
    check("t2_count", 32'(log_q.size()), 32'd2);
    check("t2_lo", 32'(lg(0)), 32'h34);
    check("t2_hi", 32'(lg(1)), 32'h12);
    if (log_cyc.size() == 2) check("t2_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd14);
    else                     check("t2_gap", 32'(log_cyc.size()), 32'd2);

    // Tie from reset goes to ALU, the next tie goes to RD.
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    clear_log();
    ALU_OUT = 16'hBEEF; RD_DATA = 8'h5A; ALU_VLD = 1'b1; RD_VLD = 1'b1;
    @(negedge CLK);
    ALU_VLD = 1'b0; RD_VLD = 1'b0;
    wait_idle("t3a");
    check("t3a_count", 32'(log_q.size()), 32'd3);
    check("t3a_b0", 32'(lg(0)), 32'hEF);
    check("t3a_b1", 32'(lg(1)), 32'hBE);
    check("t3a_b2", 32'(lg(2)), 32'h5A);
    clear_log();
    ALU_VLD = 1'b1; RD_VLD = 1'b1;
    @(negedge CLK);
    ALU_VLD = 1'b0; RD_VLD = 1'b0;
    wait_idle("t3b");
    check("t3b_count", 32'(log_q.size()), 32'd3);
    check("t3b_b0", 32'(lg(0)), 32'h5A);
    check("t3b_b1", 32'(lg(1)), 32'hEF);
    check("t3b_b2", 32'(lg(2)), 32'hBE);

    // Overflow: second read request overwrites the first before it is granted.
    clear_log();
    force_busy = 1'b1;
    pulse_rd(8'h11);
    check("t4_ovf_first", 32'(OVERFLOW), 32'd0);
    pulse_rd(8'h22);
    check("t4_ovf_set", 32'(OVERFLOW), 32'd1);
    force_busy = 1'b0;
    wait_idle("t4");
    check("t4_count", 32'(log_q.size()), 32'd1);
    check("t4_byte", 32'(lg(0)), 32'h22);
    check("t4_ovf_sticky", 32'(OVERFLOW), 32'd1);
    pulse_clr();
    check("t4_ovf_clr", 32'(OVERFLOW), 32'd0);

    // Ack timeout: busy never rises, high byte dropped.
    clear_log();
    model_en = 1'b0;
    pulse_alu(16'h5678);
    wait_strobe("t5");
    check("t5_lo", 32'(TX_P_DATA), 32'h78);
    repeat (4) @(negedge CLK);
    check("t5_ackerr_early", 32'(ACK_ERR), 32'd0);
    @(negedge CLK);
    check("t5_ackerr", 32'(ACK_ERR), 32'd1);
    check("t5_busy", 32'(SCHED_BUSY), 32'd0);
    repeat (20) @(negedge CLK);
    check("t5_count", 32'(log_q.size()), 32'd1);
    pulse_clr();
    check("t5_ackerr_clr", 32'(ACK_ERR), 32'd0);
    model_en = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset during WAIT_LO of the ALU low byte loses the transfer.
    clear_log();
    pulse_alu(16'h9ABC);
    wait_strobe("t6");
    check("t6_lo", 32'(TX_P_DATA), 32'hBC);
    repeat (5) @(negedge CLK);
    check("t6_busy_pre", 32'(SCHED_BUSY), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    check_quiet("t6_rst");
    RST = 1'b1;
    repeat (30) @(negedge CLK);
    check("t6_count", 32'(log_q.size()), 32'd1);
    check("t6_idle", 32'(SCHED_BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
